// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_n buffer and its pointer counters.
// Error-flag bit positions let a sequencer pack overflow/underflow into a status word.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;
  localparam int ERR_W   = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer 0..DEPTH-1 for the fifo_n circular buffer.
// Wrap is an explicit compare, so DEPTH need not be a power of two.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    inc,
  output logic [clog2(DEPTH)-1:0] ptr
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0] nxt;

  assign nxt = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (reset || clr)
      ptr <= '0;
    else if (inc)
      ptr <= nxt;
  end

endmodule

// File: rtl/fifo_n.sv
// Parametrised synchronous FIFO: pop-before-push, clear overrides push.
// All outputs are registered; P holds the popped value or the current head.
module fifo_n
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pop,
  input  logic                      push,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          I,
  output logic [WIDTH-1:0]          P,
  output logic                      empty,
  output logic                      full,
  output logic [clog2(DEPTH+1)-1:0] count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd;
  logic [PW-1:0]    wr;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    cnt_a;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] p_n;

  fifo_ptr #(.DEPTH(DEPTH)) u_rd (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (pop_ok),
    .ptr   (rd)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_wr (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (push_ok),
    .ptr   (wr)
  );

  always_comb begin
    pop_ok  = pop && (count != '0);
    cnt_a   = count - CW'(pop_ok);
    push_ok = push && !clear && (cnt_a < CW'(DEPTH));
    cnt_n   = clear ? '0 : cnt_a + CW'(push_ok);
    p_n     = '0;
    // any pop request owns P this edge; a failed pop shows 0
    if (pop)
      p_n = pop_ok ? mem[rd] : '0;
    else if (cnt_n != '0)
      p_n = (count == '0) ? I : mem[rd];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
      P         <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)
        mem[wr] <= I;
      P         <= p_n;
      count     <= cnt_n;
      empty     <= (cnt_n == '0);
      full      <= (cnt_n == CW'(DEPTH));
      overflow  <= push && !clear && !push_ok;
      underflow <= pop && (count == '0);
    end
  end

endmodule

// File: tb/tb_fifo_n.sv
// Directed bench for fifo_n: vector table on DEPTH=4/WIDTH=8,
// plus a wrap sequence on DEPTH=5/WIDTH=1 against a queue model.
module tb_fifo_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_pop, a_push, a_clr;
  logic [7:0] a_i, a_p;
  logic       a_e, a_f, a_o, a_u;
  logic [2:0] a_c;

  logic       b_rst, b_pop, b_push, b_clr;
  logic [0:0] b_i, b_p;
  logic       b_e, b_f, b_o, b_u;
  logic [2:0] b_c;

  int nvec = 0;
  int nerr = 0;

  fifo_n #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk       (clk),
    .reset     (a_rst),
    .pop       (a_pop),
    .push      (a_push),
    .clear     (a_clr),
    .I         (a_i),
    .P         (a_p),
    .empty     (a_e),
    .full      (a_f),
    .count     (a_c),
    .overflow  (a_o),
    .underflow (a_u)
  );

  fifo_n #(.WIDTH(1), .DEPTH(5)) dut_b (
    .clk       (clk),
    .reset     (b_rst),
    .pop       (b_pop),
    .push      (b_push),
    .clear     (b_clr),
    .I         (b_i),
    .P         (b_p),
    .empty     (b_e),
    .full      (b_f),
    .count     (b_c),
    .overflow  (b_o),
    .underflow (b_u)
  );

  typedef struct {
    logic       r, po, pu, cl;
    logic [7:0] i;
    logic [7:0] p;
    logic [2:0] c;
    logic       e, f, o, u;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic po, logic pu, logic cl, logic [7:0] i,
    logic [7:0] p, logic [2:0] c,
    logic e, logic f, logic o, logic u);
    vec_t v;
    v.r = r; v.po = po; v.pu = pu; v.cl = cl; v.i = i;
    v.p = p; v.c = c; v.e = e; v.f = f; v.o = o; v.u = u;
    return v;
  endfunction

  task automatic step_b(input logic r, input logic po,
                        input logic pu, input logic d);
    b_rst = r; b_pop = po; b_push = pu; b_clr = 1'b0; b_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic ep,
                       input logic [2:0] ec, input logic ee,
                       input logic ef);
    nvec++;
    if ({b_p, b_c, b_e, b_f, b_o, b_u} !==
        {ep, ec, ee, ef, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL %s: got P=%b cnt=%0d e=%b f=%b ovf=%b unf=%b, want P=%b cnt=%0d e=%b f=%b ovf=0 unf=0",
               nm, b_p, b_c, b_e, b_f, b_o, b_u, ep, ec, ee, ef);
    end
  endtask

  initial begin
    logic       q[$];
    logic [4:0] bits;
    logic       d, ex;

    b_rst = 1'b1; b_pop = 1'b0; b_push = 1'b0; b_clr = 1'b0; b_i = '0;

    //               r po pu cl  I      P     c  e  f  o  u
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h22, 8'h11, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h33, 8'h11, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h11, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h22, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h01, 8'h01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h02, 8'h01, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h03, 8'h01, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h04, 8'h01, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h05, 8'h01, 4, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h01, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h01, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h02, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h03, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h04, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h01, 8'h01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h02, 8'h01, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h03, 8'h01, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h04, 8'h01, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 8'h09, 8'h01, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h02, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h03, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h04, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h09, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 8'hAA, 8'h00, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'hAA, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h10, 8'h10, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h20, 8'h10, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 8'h30, 8'h10, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h10, 8'h10, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h20, 8'h10, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h55, 8'h55, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h66, 8'h55, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 8'h77, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h01, 8'h01, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h02, 8'h01, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h03, 8'h01, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h04, 8'h01, 4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 8'h08, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));

    foreach (tbl[k]) begin
      a_rst = tbl[k].r; a_pop = tbl[k].po; a_push = tbl[k].pu;
      a_clr = tbl[k].cl; a_i = tbl[k].i;
      @(posedge clk);
      #1;
      nvec++;
      if ({a_p, a_c, a_e, a_f, a_o, a_u} !==
          {tbl[k].p, tbl[k].c, tbl[k].e, tbl[k].f, tbl[k].o, tbl[k].u}) begin
        nerr++;
        $display("FAIL vec%0d: got P=%h cnt=%0d e=%b f=%b ovf=%b unf=%b, want P=%h cnt=%0d e=%b f=%b ovf=%b unf=%b",
                 k, a_p, a_c, a_e, a_f, a_o, a_u,
                 tbl[k].p, tbl[k].c, tbl[k].e, tbl[k].f, tbl[k].o, tbl[k].u);
      end
    end

    step_b(1'b1, 1'b0, 1'b0, 1'b0);
    chk_b("b_rst", 1'b0, 3'd0, 1'b1, 1'b0);
    bits = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      d = bits[k];
      q.push_back(d);
      step_b(1'b0, 1'b0, 1'b1, d);
      chk_b("b_fill", q[0], 3'(k + 1), 1'b0, k == 4);
    end
    for (int k = 0; k < 8; k++) begin
      d  = (k % 3 == 0);
      ex = q.pop_front();
      q.push_back(d);
      step_b(1'b0, 1'b1, 1'b1, d);
      chk_b("b_pushpop", ex, 3'd5, 1'b0, 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      ex = q.pop_front();
      step_b(1'b0, 1'b1, 1'b0, 1'b0);
      chk_b("b_drain", ex, 3'(4 - k), k == 4, 1'b0);
    end
    step_b(1'b0, 1'b0, 1'b0, 1'b0);
    chk_b("b_idle", 1'b0, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
